// File: rtl/jtkunio_mcu_comm_pkg.sv
// Shared definitions for the Kunio main-CPU <-> protection-MCU mailbox.
// Holds the status bit positions seen on cabinet input port 2, the I/O
// offset the main decoder uses for the mailbox slot, and the access type.
package jtkunio_mcu_comm_pkg;

  // Bit positions of the two full flags in mcu_st / ovr
  localparam int MCU_ST_M2S = 0;
  localparam int MCU_ST_S2M = 1;

  // Offset of the mailbox within the main CPU I/O block
  localparam logic [3:0] MCU_IO_OFFSET = 4'd4;

  // One qualified access to a single mailbox latch
  typedef struct packed {
    logic wr;
    logic rd;
  } mbox_acc_t;

  // Gate raw write/read requests with the owning CPU's cycle enable
  function automatic mbox_acc_t qualify(input logic cen, input logic wr, input logic rd);
    mbox_acc_t acc;
    acc.wr = cen & wr;
    acc.rd = cen & rd;
    return acc;
  endfunction

endpackage

// File: rtl/jtkunio_mcu_latch.sv
// One direction of the mailbox: an 8-bit one-deep latch with a full flag
// and a sticky overrun flag. A write and a read on the same edge resolve
// in favour of the write: new data, flag stays set, no overrun.
module jtkunio_mcu_latch #(
  parameter logic [7:0] RST_DATA = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       ovr
);

  logic [7:0] data_q, data_d;
  logic       full_q, full_d;
  logic       ovr_q,  ovr_d;

  // Next-state: write loads data and sets full, read alone clears full
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no inferred latch).
    data_d = data_q;
    full_d = full_q;
    ovr_d  = ovr_q;
    if (wr) begin
      data_d = din;
      full_d = 1'b1;
      // Overwriting unread data is an overrun unless the reader takes it this same edge
      if (full_q && !rd) ovr_d = 1'b1;
    end else if (rd) begin
      full_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is a single word, so it is reset to a known value; resetting is cheap here unlike a RAM array.
      data_q <= RST_DATA;
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      data_q <= data_d;
      full_q <= full_d;
      ovr_q  <= ovr_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/jtkunio_mcu_comm.sv
// Kunio main 6502 <-> protection MCU mailbox. The top only qualifies the
// accesses of each CPU with its cycle enable and maps the two latches onto
// the status, interrupt and overrun outputs.
module jtkunio_mcu_comm
  import jtkunio_mcu_comm_pkg::*;
#(
  parameter logic [7:0] RST_DATA = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       main_cen,
  input  logic       main_cs,
  input  logic       main_rnw,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  output logic [1:0] mcu_st,
  input  logic       mcu_cen,
  input  logic       mcu_rd,
  input  logic       mcu_wr,
  input  logic [7:0] mcu_din,
  output logic [7:0] mcu_dout,
  output logic       mcu_irq_n,
  output logic [1:0] ovr
);

  mbox_acc_t main_acc;
  mbox_acc_t mcu_acc;
  logic      m2s_full, s2m_full;
  logic      m2s_ovr,  s2m_ovr;

  // One access per enabled edge; main_cs held across several edges counts only on main_cen
  always_comb begin
    main_acc = qualify(main_cen & main_cs, ~main_rnw, main_rnw);
    mcu_acc  = qualify(mcu_cen, mcu_wr, mcu_rd);
  end

  // Main -> MCU direction
  jtkunio_mcu_latch #(.RST_DATA(RST_DATA)) u_m2s (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (main_acc.wr),
    .rd    (mcu_acc.rd),
    .din   (main_din),
    .dout  (mcu_dout),
    .full  (m2s_full),
    .ovr   (m2s_ovr)
  );

  // MCU -> main direction
  jtkunio_mcu_latch #(.RST_DATA(RST_DATA)) u_s2m (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (mcu_acc.wr),
    .rd    (main_acc.rd),
    .din   (mcu_din),
    .dout  (main_dout),
    .full  (s2m_full),
    .ovr   (s2m_ovr)
  );

  // Status, overrun and interrupt mapping
  always_comb begin
    mcu_st             = 2'b00;
    ovr                = 2'b00;
    mcu_st[MCU_ST_M2S] = m2s_full;
    mcu_st[MCU_ST_S2M] = s2m_full;
    ovr[MCU_ST_M2S]    = m2s_ovr;
    ovr[MCU_ST_S2M]    = s2m_ovr;
    mcu_irq_n          = ~m2s_full;
  end

endmodule

// File: tb/tb_jtkunio_mcu_comm.sv
// Self-checking bench for the Kunio MCU mailbox: directed scenarios followed
// by random traffic, all compared against a transaction-level mailbox model.
module tb_jtkunio_mcu_comm;

  localparam logic [7:0] RST_DATA = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       main_cen, main_cs, main_rnw;
  logic [7:0] main_din, main_dout;
  logic [1:0] mcu_st;
  logic       mcu_cen, mcu_rd, mcu_wr;
  logic [7:0] mcu_din, mcu_dout;
  logic       mcu_irq_n;
  logic [1:0] ovr;

  int n_assert = 0;
  int n_fail   = 0;

  // Mailbox model: two boxes, each holding a byte, a pending flag and a sticky overrun
  logic [7:0] mdl_data [2];
  bit         mdl_full [2];
  bit         mdl_ovr  [2];

  jtkunio_mcu_comm #(.RST_DATA(RST_DATA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .main_cen  (main_cen),
    .main_cs   (main_cs),
    .main_rnw  (main_rnw),
    .main_din  (main_din),
    .main_dout (main_dout),
    .mcu_st    (mcu_st),
    .mcu_cen   (mcu_cen),
    .mcu_rd    (mcu_rd),
    .mcu_wr    (mcu_wr),
    .mcu_din   (mcu_din),
    .mcu_dout  (mcu_dout),
    .mcu_irq_n (mcu_irq_n),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mdl_data[i] = RST_DATA;
      mdl_full[i] = 0;
      mdl_ovr[i]  = 0;
    end
  endtask

  // Box b receives a message (put) and/or is drained (take) on one edge
  task automatic model_box(input int b, input bit put, input bit take, input logic [7:0] val);
    if (put) begin
      if (mdl_full[b] && !take) mdl_ovr[b] = 1;
      mdl_data[b] = val;
      mdl_full[b] = 1;
    end else if (take) begin
      mdl_full[b] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mcu_st"},    {6'd0, mcu_st}, {6'd0, mdl_full[1], mdl_full[0]});
    check({tag, ".irq_n"},     {7'd0, mcu_irq_n}, {7'd0, !mdl_full[0]});
    check({tag, ".ovr"},       {6'd0, ovr}, {6'd0, mdl_ovr[1], mdl_ovr[0]});
    check({tag, ".mcu_dout"},  mcu_dout, mdl_data[0]);
    check({tag, ".main_dout"}, main_dout, mdl_data[1]);
  endtask

  // Drive one clock cycle of inputs (starting at a negedge), check reader data
  // before the edge, update the model on the edge, return at the next negedge.
  task automatic cyc(input bit m_cen, input bit m_cs, input bit m_rnw, input logic [7:0] m_din,
                     input bit s_cen, input bit s_rd, input bit s_wr, input logic [7:0] s_din,
                     input bit chk_rd);
    bit m_put, m_take, s_put, s_take;
    main_cen = m_cen; main_cs = m_cs; main_rnw = m_rnw; main_din = m_din;
    mcu_cen  = s_cen; mcu_rd  = s_rd; mcu_wr   = s_wr;  mcu_din  = s_din;
    m_put  = m_cen && m_cs && !m_rnw;
    m_take = m_cen && m_cs && m_rnw;
    s_put  = s_cen && s_wr;
    s_take = s_cen && s_rd;
    #1;
    if (chk_rd && s_take) check("mcu_read_data", mcu_dout, mdl_data[0]);
    if (chk_rd && m_take) check("main_read_data", main_dout, mdl_data[1]);
    @(posedge clk);
    model_box(0, m_put, s_take, m_din);
    model_box(1, s_put, m_take, s_din);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    main_cen = 0; main_cs = 0; main_rnw = 1; main_din = 0;
    mcu_cen = 0; mcu_rd = 0; mcu_wr = 0; mcu_din = 0;
    model_reset();
    #12;
    check_all("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check_all("reset_release");

    // Main write A5 with main_cs held 16 clocks across a single main_cen pulse
    for (int i = 0; i < 16; i++) cyc(i == 7, 1, 0, 8'hA5, 0, 0, 0, 8'h00, 0);
    idle();
    check_all("main_wr_a5");
    check("a5_mcu_dout", mcu_dout, 8'hA5);
    check("a5_st", {6'd0, mcu_st}, 8'h01);
    check("a5_irq", {7'd0, mcu_irq_n}, 8'h00);

    // MCU reads it back
    cyc(0, 0, 1, 8'h00, 1, 1, 0, 8'h00, 1);
    check_all("mcu_rd_a5");
    check("rd_a5_st", {6'd0, mcu_st}, 8'h00);

    // MCU writes 3C, main reads it twice
    cyc(0, 0, 1, 8'h00, 1, 0, 1, 8'h3C, 0);
    check_all("mcu_wr_3c");
    check("3c_main_dout", main_dout, 8'h3C);
    check("3c_st", {6'd0, mcu_st}, 8'h02);
    cyc(1, 1, 1, 8'h00, 0, 0, 0, 8'h00, 1);
    check_all("main_rd_1");
    cyc(1, 1, 1, 8'h00, 0, 0, 0, 8'h00, 1);
    check_all("main_rd_2");

    // Two main writes without an MCU read: overrun
    cyc(1, 1, 0, 8'h11, 0, 0, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h22, 0, 0, 0, 8'h00, 0);
    check_all("overrun");
    check("ovr_data", mcu_dout, 8'h22);
    check("ovr_flags", {6'd0, ovr}, 8'h01);
    cyc(0, 0, 1, 8'h00, 1, 1, 0, 8'h00, 1);
    check_all("overrun_rd");

    // Fresh reset, then same-edge main write 77 and MCU read of prior 55
    rst_n = 1'b0; model_reset(); #1;
    check_all("reset_mid");
    rst_n = 1'b1;
    idle();
    cyc(1, 1, 0, 8'h55, 0, 0, 0, 8'h00, 0);
    main_cen = 1; main_cs = 1; main_rnw = 0; main_din = 8'h77;
    mcu_cen = 1; mcu_rd = 1; mcu_wr = 0;
    #1;
    check("same_edge_pre", mcu_dout, 8'h55);
    cyc(1, 1, 0, 8'h77, 1, 1, 0, 8'h00, 1);
    check_all("same_edge");
    check("same_edge_dout", mcu_dout, 8'h77);
    check("same_edge_ovr", {6'd0, ovr}, 8'h00);

    // Strobes without their cycle enables do nothing
    cyc(0, 1, 0, 8'hEE, 0, 1, 1, 8'hDD, 0);
    cyc(0, 1, 1, 8'hEE, 0, 1, 0, 8'hDD, 0);
    check_all("no_cen");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), 1);
      check_all("random");
    end

    // Fill both latches with overruns, then reset asynchronously mid-cycle
    cyc(1, 1, 0, 8'h12, 1, 0, 1, 8'h34, 0);
    cyc(1, 1, 0, 8'h56, 1, 0, 1, 8'h78, 0);
    idle();
    check_all("both_full");
    check("both_full_ovr", {6'd0, ovr}, 8'h03);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    check("async_irq", {7'd0, mcu_irq_n}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
